// File: rtl/binary_search_4bit.sv
// Successive-approximation controller: drives a guess into a magnitude comparator
// and narrows [lo, hi] from the low/equal/great flags until the hidden operand is found.
module binary_search_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             low,
  input  logic             equal,
  input  logic             great,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       steps
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;

  state_t           state;
  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH:0]   sum_gt, sum_lt;
  logic             onehot;

  // Midpoint sums kept one bit wider so lo+hi never overflows before the floor shift.
  always_comb begin
    sum_gt = {1'b0, lo} + {1'b0, guess} - (WIDTH+1)'(1);
    sum_lt = {1'b0, guess} + (WIDTH+1)'(1) + {1'b0, hi};
    onehot = $onehot({low, equal, great});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      steps  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lo     <= '0;
            hi     <= MAXV;
            guess  <= MAXV >> 1;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            steps  <= '0;
            busy   <= 1'b1;
            state  <= PROBE;
          end
        end
        PROBE: begin
          steps <= steps + 3'd1;
          if (!onehot) begin
            err   <= 1'b1;
            found <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (equal) begin
            result <= guess;
            found  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (great) begin
            if (guess == lo) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              hi    <= guess - WIDTH'(1);
              guess <= WIDTH'(sum_gt >> 1);
            end
          end else begin
            // low: the target lies strictly above the current guess
            if (guess == hi) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              lo    <= guess + WIDTH'(1);
              guess <= WIDTH'(sum_lt >> 1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_search_4bit.sv
// Scoreboard bench: a comparator model answers the guesses, a reference search
// predicts guesses and results, and monitors compare on busy and done.
module tb_binary_search_4bit;

  localparam int W = 4;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         start = 0;
  logic         low, equal, great;
  logic [W-1:0] guess, result;
  logic         busy, done, found, err;
  logic [2:0]   steps;

  logic [W-1:0] target = '0;
  int           mode = 0;   // 0 real comparator, 1 flags 000, 2 always great
  int           cyc = 0;
  int           start_cyc = 0;
  int           checks = 0;
  int           passes = 0;

  typedef struct {
    int res;
    int fnd;
    int er;
    int stp;
  } exp_t;

  exp_t exp_q[$];
  int   expg_q[$];

  binary_search_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .low(low), .equal(equal), .great(great),
    .guess(guess), .busy(busy), .done(done), .found(found),
    .err(err), .result(result), .steps(steps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    low = 1'b0; equal = 1'b0; great = 1'b0;
    case (mode)
      0: begin
        low   = guess < target;
        equal = guess == target;
        great = guess > target;
      end
      2: great = 1'b1;
      default: ;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference search over integer interval [lo, hi] with floor midpoints.
  task automatic push_model(input int t, input int md);
    int lo, hi, g;
    bit lt, eq, gt;
    exp_t e;
    lo = 0; hi = (1 << W) - 1; g = hi / 2;
    e.res = 0; e.fnd = 0; e.er = 0; e.stp = 0;
    forever begin
      expg_q.push_back(g);
      e.stp++;
      lt = (md == 0) && (g < t);
      eq = (md == 0) && (g == t);
      gt = (md == 2) || ((md == 0) && (g > t));
      if (int'(lt) + int'(eq) + int'(gt) != 1) begin e.er = 1; break; end
      if (eq) begin e.res = g; e.fnd = 1; break; end
      if (gt) begin
        if (g == lo) begin e.er = 1; break; end
        hi = g - 1;
      end else begin
        if (g == hi) begin e.er = 1; break; end
        lo = g + 1;
      end
      g = (lo + hi) / 2;
    end
    exp_q.push_back(e);
  endtask

  // Guess monitor: every busy cycle must show the next predicted probe.
  always @(negedge clk) begin
    if (busy) begin
      if (expg_q.size() == 0) chk("guess_unexpected", 1, 0);
      else chk("guess", guess, expg_q.pop_front());
    end
  end

  // Result monitor: fires on the done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("found", found, e.fnd);
        chk("err", err, e.er);
        chk("steps", steps, e.stp);
        chk("steps_le5", int'(steps <= 3'd5), 1);
        chk("latency", cyc - start_cyc + 1, e.stp + 1);
        chk("busy_with_done", busy, 0);
      end
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int t, input int md);
    @(negedge clk);
    target = W'(t); mode = md; start = 1;
    push_model(t, md);
    @(posedge clk); #1;
    start_cyc = cyc; start = 0;
    wait_done();
    @(posedge clk);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_guess"}, guess, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_found"}, found, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_result"}, result, 0);
    chk({nm, "_steps"}, steps, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1;

    run(7, 0);
    run(15, 0);
    run(0, 0);
    run(9, 1);
    run(5, 2);

    // start held high: ignored while busy, restarts on the first IDLE edge after done
    @(negedge clk);
    target = 4'd11; mode = 0; start = 1;
    push_model(11, 0);
    @(posedge clk); #1 start_cyc = cyc;
    wait_done();
    push_model(11, 0);
    @(posedge clk);
    @(posedge clk); #1;
    start_cyc = cyc;
    chk("restart_busy", busy, 1);
    chk("restart_found", found, 0);
    chk("restart_result", result, 0);
    start = 0;
    wait_done();
    @(posedge clk);

    // reset during the second probe aborts without a done pulse
    @(negedge clk);
    target = 4'd13; mode = 0; start = 1;
    expg_q.push_back(7);
    expg_q.push_back(11);
    @(posedge clk); #1 start = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1 check_zero("abort");
    @(negedge clk) rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    run(13, 0);

    for (int t = 0; t < 16; t++) run(t, 0);
    for (int i = 0; i < 20; i++) begin
      int md;
      md = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run(int'($urandom_range(0, 15)), md);
    end

    repeat (3) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("expg_q_drained", expg_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
